// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and helpers.
// Optional rotate support is compiled in when UNIV_SHREG_ROTATE_EN is defined.
package shreg_pkg;

    localparam int unsigned MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_LOAD = 3'b001;
    localparam mode_t MODE_SHL  = 3'b010;
    localparam mode_t MODE_SHR  = 3'b011;
    localparam mode_t MODE_ROTL = 3'b100;
    localparam mode_t MODE_ROTR = 3'b101;

    // True for every mode that moves data by one position and advances the shift count.
    function automatic logic is_shift_mode(input mode_t m);
        logic r;
        r = (m == MODE_SHL) || (m == MODE_SHR);
`ifdef UNIV_SHREG_ROTATE_EN
        r = r || (m == MODE_ROTL) || (m == MODE_ROTR);
`endif
        return r;
    endfunction

    // True for modes whose data moves towards the MSB.
    function automatic logic is_left_mode(input mode_t m);
        logic r;
        r = (m == MODE_SHL);
`ifdef UNIV_SHREG_ROTATE_EN
        r = r || (m == MODE_ROTL);
`endif
        return r;
    endfunction

endpackage

// File: rtl/shreg_bit_cell.sv
// One bit of the universal shift register: next-state select plus storage flop.
// right_nbr is the bit below this one (source on a left move), left_nbr the bit above
// (source on a right move); end-bit wrapping is resolved by the parent.
// Rotate modes are honoured only when UNIV_SHREG_ROTATE_EN is defined.
module shreg_bit_cell
    import shreg_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  reset_val,
    input  logic  set,
    input  logic  enable,
    input  mode_t mode,
    input  logic  d,
    input  logic  left_nbr,
    input  logic  right_nbr,
    output logic  q
);

    logic q_nxt;

    // Select the value this bit takes when the register is enabled.
    always_comb begin
        q_nxt = q;
        case (mode)
            MODE_LOAD: q_nxt = d;
            MODE_SHL:  q_nxt = right_nbr;
            MODE_SHR:  q_nxt = left_nbr;
`ifdef UNIV_SHREG_ROTATE_EN
            MODE_ROTL: q_nxt = right_nbr;
            MODE_ROTR: q_nxt = left_nbr;
`endif
            default:   q_nxt = q;
        endcase
    end

    // Storage with reset > set > enable > hold priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= reset_val;
        end else if (set) begin
            q <= 1'b1;
        end else if (enable) begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Parametrised universal register: parallel load, logical shifts with serial inputs,
// optional rotate, registered serial output and a saturating shift counter.
// Define UNIV_SHREG_ROTATE_EN to enable modes ROTL/ROTR; otherwise they act as HOLD.
module universal_shift_reg
    import shreg_pkg::*;
#(
    parameter int unsigned       WIDTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    localparam int unsigned      CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             enable,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] D_in,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] Q_out,
    output logic             sout,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             full_shifted
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] right_nbr;
    logic [WIDTH-1:0] left_nbr;
    logic             shift_c;
    logic             sout_nxt;
    logic [CNT_W-1:0] cnt_inc;

    // Neighbour wiring: serial inputs at the ends, or the wrapped end bit when rotating.
    always_comb begin
        right_nbr = {q[WIDTH-2:0], sin_l};
        left_nbr  = {sin_r, q[WIDTH-1:1]};
`ifdef UNIV_SHREG_ROTATE_EN
        if (mode == MODE_ROTL) begin
            right_nbr[0] = q[WIDTH-1];
        end
        if (mode == MODE_ROTR) begin
            left_nbr[WIDTH-1] = q[0];
        end
`endif
    end

    // Per-bit cells.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        shreg_bit_cell u_cell (
            .clk       (clk),
            .reset     (reset),
            .reset_val (RESET_VAL[i]),
            .set       (set),
            .enable    (enable),
            .mode      (mode),
            .d         (D_in[i]),
            .left_nbr  (left_nbr[i]),
            .right_nbr (right_nbr[i]),
            .q         (q[i])
        );
    end

    assign Q_out = q;

    // Shift decode, outgoing bit and saturating count increment.
    always_comb begin
        shift_c  = is_shift_mode(mode);
        sout_nxt = is_left_mode(mode) ? q[WIDTH-1] : q[0];
        cnt_inc  = (shift_cnt == CNT_MAX) ? shift_cnt : shift_cnt + CNT_W'(1);
    end

    // Serial output, shift counter and completion flag.
    always_ff @(posedge clk) begin
        if (reset || set) begin
            sout         <= 1'b0;
            shift_cnt    <= '0;
            full_shifted <= 1'b0;
        end else if (enable) begin
            if (mode == MODE_LOAD) begin
                shift_cnt    <= '0;
                full_shifted <= 1'b0;
            end else if (shift_c) begin
                sout         <= sout_nxt;
                shift_cnt    <= cnt_inc;
                full_shifted <= (cnt_inc == CNT_MAX);
            end
        end
    end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg: a 4-bit (reset 0) and an 8-bit (reset A5)
// instance share stimulus; an arithmetic reference model predicts each edge.
module tb_universal_shift_reg;

    localparam int M_HOLD = 0;
    localparam int M_LOAD = 1;
    localparam int M_SHL  = 2;
    localparam int M_SHR  = 3;
    localparam int M_ROTL = 4;
    localparam int M_ROTR = 5;
`ifdef UNIV_SHREG_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    typedef struct {
        int q;
        int sout;
        int cnt;
    } mstate_t;

    typedef struct {
        mstate_t a;
        mstate_t b;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       set = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] din = 8'd0;
    logic       sin_l = 1'b0;
    logic       sin_r = 1'b0;

    logic [3:0] q4;
    logic       sout4;
    logic [2:0] cnt4;
    logic       full4;
    logic [7:0] q8;
    logic       sout8;
    logic [3:0] cnt8;
    logic       full8;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    mstate_t ma, mb;

    always #5 clk = ~clk;

    universal_shift_reg u4 (
        .clk(clk), .reset(reset), .set(set), .enable(enable), .mode(mode),
        .D_in(din[3:0]), .sin_l(sin_l), .sin_r(sin_r),
        .Q_out(q4), .sout(sout4), .shift_cnt(cnt4), .full_shifted(full4)
    );

    universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) u8 (
        .clk(clk), .reset(reset), .set(set), .enable(enable), .mode(mode),
        .D_in(din), .sin_l(sin_l), .sin_r(sin_r),
        .Q_out(q8), .sout(sout8), .shift_cnt(cnt8), .full_shifted(full8)
    );

    // Reference model: one clock edge of a w-bit universal register, in plain arithmetic.
    function automatic mstate_t ref_step(input mstate_t s, input int w, input int rv,
                                         input bit r, input bit st, input bit en,
                                         input int md, input int d, input bit sl, input bit sr);
        mstate_t n;
        int mask;
        bit moving, left;
        int fill;
        n = s;
        mask = (1 << w) - 1;
        moving = (md == M_SHL) || (md == M_SHR) || (ROT_EN && (md == M_ROTL || md == M_ROTR));
        left = (md == M_SHL) || (md == M_ROTL);
        if (r) begin
            n.q = rv; n.sout = 0; n.cnt = 0;
        end else if (st) begin
            n.q = mask; n.sout = 0; n.cnt = 0;
        end else if (en) begin
            if (md == M_LOAD) begin
                n.q = d & mask; n.cnt = 0;
            end else if (moving) begin
                case (md)
                    M_SHL:   fill = sl;
                    M_SHR:   fill = sr;
                    M_ROTL:  fill = (s.q >> (w - 1)) & 1;
                    default: fill = s.q & 1;
                endcase
                n.sout = left ? ((s.q >> (w - 1)) & 1) : (s.q & 1);
                n.q = left ? (((s.q << 1) | fill) & mask) : ((s.q >> 1) | (fill << (w - 1)));
                n.cnt = (s.cnt < w) ? s.cnt + 1 : w;
            end
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int expv);
        n_vec++;
        if (act !== 32'(expv)) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the predicted result.
    task automatic step(input bit r, input bit st, input bit en, input int md,
                        input int d, input bit sl, input bit sr);
        exp_t e;
        @(negedge clk);
        reset = r; set = st; enable = en; mode = 3'(md);
        din = 8'(d); sin_l = sl; sin_r = sr;
        ma = ref_step(ma, 4, 0, r, st, en, md, d, sl, sr);
        mb = ref_step(mb, 8, 8'hA5, r, st, en, md, d, sl, sr);
        e.a = ma;
        e.b = mb;
        sb.push_back(e);
    endtask

    // Monitor: after every rising edge, compare both instances against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q4",    32'(q4),    e.a.q);
                chk("sout4", 32'(sout4), e.a.sout);
                chk("cnt4",  32'(cnt4),  e.a.cnt);
                chk("full4", 32'(full4), int'(e.a.cnt == 4));
                chk("q8",    32'(q8),    e.b.q);
                chk("sout8", 32'(sout8), e.b.sout);
                chk("cnt8",  32'(cnt8),  e.b.cnt);
                chk("full8", 32'(full8), int'(e.b.cnt == 8));
            end
        end
    end

    initial begin
        ma = '{0, 0, 0};
        mb = '{0, 0, 0};

        // Reset wins over a pending load.
        step(1, 0, 1, M_LOAD, 8'hFA, 0, 0);
        // 8-bit instance shifts A5 right with sin_r=0 -> 52, sout=1.
        step(0, 0, 1, M_SHR, 0, 0, 0);

        // Load 1010 then shift left five times with sin_l=1 (saturation on the fifth).
        step(0, 0, 1, M_LOAD, 8'h3A, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, M_SHL, 0, 1, 0);

        // Enable low holds everything regardless of mode.
        step(0, 0, 1, M_LOAD, 8'h96, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, M_SHR, 8'hFF, 1, 1);

        // Priority: set beats load, reset beats set.
        step(0, 1, 1, M_LOAD, 0, 0, 0);
        step(1, 1, 1, M_LOAD, 0, 0, 0);

        // Rotate right four times from 1000 (hold when rotate is compiled out).
        step(0, 0, 1, M_LOAD, 8'h18, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, M_ROTR, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, M_ROTL, 0, 0, 0);

        // Reserved modes hold.
        step(0, 0, 1, 6, 8'h00, 1, 1);
        step(0, 0, 1, 7, 8'h00, 1, 1);

        // Long right shift to saturate the 8-bit counter, then reset mid-sequence.
        step(0, 0, 1, M_LOAD, 8'hC3, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, M_SHR, 0, 0, i % 2);
        step(1, 0, 1, M_SHR, 0, 0, 1);

        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 4) != 0), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d predictions left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised WIDTH-bit universal register built from a generate loop of per-bit cells.
- Successor to the fixed 4-bit D-register bank.
- Adds parallel load, logical shift left/right with serial inputs, optional rotate, and a shift counter with a completion flag.
- Used as a general storage, serialiser and deserialiser element in the practice designs.

Parameters:
- WIDTH, 4: register width in bits; legal range is 2 and up.
- RESET_VAL, 0: value loaded into q_out by reset; WIDTH bits wide.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- set  input  1  synchronous preset: drives all q_out bits to 1.
- enable  input  1  clock enable for every operation below set.
- mode  input  3  operation select; encodings defined in the package.
- D_in  input  WIDTH  parallel load data.
- sin_l  input  1  serial input, enters at the LSB on a shift left.
- sin_r  input  1  serial input, enters at the MSB on a shift right.
- Q_out  output  WIDTH  register contents.
- sout  output  1  bit shifted out on the last shift; registered.
- shift_cnt  output  $clog2(WIDTH+1)  number of shifts since the last load, reset or set.
- full_shifted  output  1  high while shift_cnt equals WIDTH.

Behaviour:
- Single clock domain. All state changes occur on the rising edge of clk.
- There is no combinational path from inputs to outputs.

Priority at each edge: reset > set > enable > hold.
- reset=1: Q_out=RESET_VAL, sout=0, shift_cnt=0, full_shifted=0.
- set=1 (reset=0): Q_out all ones, sout=0, shift_cnt=0.
- enable=0: all state holds regardless of mode.

Modes (applied when enable=1):
- 000 HOLD: no change.
- 001 LOAD: Q_out=D_in, shift_cnt=0, sout unchanged.
- 010 SHL: Q_out={Q_out[WIDTH-2:0],sin_l}, sout=old Q_out[WIDTH-1].
- 011 SHR: Q_out={sin_r,Q_out[WIDTH-1:1]}, sout=old Q_out[0].
- 100 ROTL: Q_out={Q_out[WIDTH-2:0],Q_out[WIDTH-1]}, sout=old MSB.
- 101 ROTR: Q_out={Q_out[0],Q_out[WIDTH-1:1]}, sout=old LSB.
- 110 and 111 are reserved and behave as HOLD.

shift_cnt:
- Increments by 1 on every executed shift or rotate.
- Saturates at WIDTH and never wraps.
- full_shifted is registered and equals (shift_cnt==WIDTH) as a function of the updated count. It is therefore high in the same cycle shift_cnt reaches WIDTH.

Latency: one cycle from a sampled input to the updated Q_out.

Boundary cases:
- reset asserted mid-sequence: the counter clears immediately; no partial state survives.
- set together with any mode: set wins and the mode is ignored.
- Shift at a saturated count: data still shifts; the count stays at WIDTH.

Optional Feature:
- Macro: UNIV_SHREG_ROTATE_EN.
- Defined: modes 100 and 101 rotate as specified above.
- Not defined: modes 100 and 101 behave as HOLD, with no count change and no sout change. The rotate mux logic is absent from the netlist.

Decomposition:
- Package shreg_pkg holds:
  - mode localparams: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR.
  - width of the mode field: MODE_W=3.
- Sub-module shreg_bit_cell, one per bit, instanced from a generate loop.
  - Inputs: clk, reset, reset_val, set, enable, mode, d, left_nbr, right_nbr.
  - Output: q.
  - Contains the next-state mux and the flop.
- The top level contains:
  - neighbour wiring, including sin_l/sin_r and the rotate wrap at the end bits;
  - the sout register;
  - the shift counter and full_shifted logic.

Test Plan (WIDTH=4, RESET_VAL=0 unless stated):
1. Reset: drive reset=1 with mode=LOAD and D_in=1010. After the edge, Q_out=0000, shift_cnt=0, full_shifted=0.
2. Load then SHL four times with sin_l=1, starting from D_in=1010.
   - Q_out sequence: 0101, 1011, 0111, 1111.
   - sout sequence: 1, 0, 1, 0.
   - full_shifted rises on the 4th shift; a 5th shift leaves shift_cnt=4.
3. Enable low: load 0110, then enable=0 with mode=SHR for 3 cycles. Q_out stays 0110 and shift_cnt stays 0.
4. Priority: set=1 with mode=LOAD and D_in=0000 gives Q_out=1111. reset=1 together with set=1 gives Q_out=0000.
5. Rotate, with UNIV_SHREG_ROTATE_EN defined: load 1000, then ROTR gives 0100 with sout=0. Rotating four times in total returns to 1000 with full_shifted=1.
   - Same test without the macro: Q_out stays 1000 and shift_cnt stays 0.
6. WIDTH=8, RESET_VAL=8'hA5: reset gives Q_out=A5. Then SHR with sin_r=0 gives 52 and sout=1.
